// File: rtl/peripheral_bus_bridge_if.sv
// Request/response bus between the system fabric (master) and the
// counter-peripheral bridge (slave). One transaction outstanding at a time.
interface peripheral_bus_bridge_if;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_req_write;
  logic [11:0] bus_req_addr;
  logic [31:0] bus_req_wdata;
  logic        bus_rsp_valid;
  logic        bus_rsp_ready;
  logic [31:0] bus_rsp_rdata;
  logic        bus_rsp_err;

  modport master (
    output bus_req_valid, bus_req_write, bus_req_addr, bus_req_wdata, bus_rsp_ready,
    input  bus_req_ready, bus_rsp_valid, bus_rsp_rdata, bus_rsp_err
  );

  modport slave (
    input  bus_req_valid, bus_req_write, bus_req_addr, bus_req_wdata, bus_rsp_ready,
    output bus_req_ready, bus_rsp_valid, bus_rsp_rdata, bus_rsp_err
  );
endinterface

// File: rtl/peripheral_bus_bridge.sv
// Bus-side initiator for the counter peripheral. Accepts one word transaction
// at a time, decodes COUNT / CONFIG / STATUS / memory window, drives the
// core's load strobes and the single-port memory, and returns data or error.
// Every output toggles only from a flop so the core sees glitch-free strobes.
module peripheral_bus_bridge #(
  parameter logic [11:0] MEM_BASE  = 12'h400,
  parameter int          MEM_DEPTH = 256
) (
  input  logic                         clk,
  input  logic                         reset,
  peripheral_bus_bridge_if.slave       bus,
  output logic                         count_we,
  output logic [31:0]                  count_in,
  output logic                         count_config_we,
  output logic                         count_en_in,
  output logic                         count_dir_in,
  output logic                         count_ire_in,
  input  logic [31:0]                  count_out,
  input  logic                         count_en_out,
  input  logic                         count_dir_out,
  input  logic                         count_ire_out,
  input  logic                         count_lt_1k_out,
  output logic                         mem_write_en,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_address,
  output logic [31:0]                  mem_data_in,
  input  logic [31:0]                  mem_data_out
);

  localparam int          AW       = $clog2(MEM_DEPTH);
  localparam logic [11:0] MEM_LAST = MEM_BASE + 12'(MEM_DEPTH * 4 - 4);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_EXEC     = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_RESP     = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    K_COUNT  = 3'd0,
    K_CONFIG = 3'd1,
    K_STATUS = 3'd2,
    K_MEM    = 3'd3,
    K_ERR    = 3'd4
  } kind_e;

  // Classify a request; writes to the read-only STATUS word are errors.
  function automatic kind_e decode(input logic [11:0] addr, input logic wr);
    kind_e k;
    if (addr[1:0] != 2'b00) begin
      k = K_ERR;
    end else if (addr == 12'h000) begin
      k = K_COUNT;
    end else if (addr == 12'h004) begin
      k = K_CONFIG;
    end else if (addr == 12'h008) begin
      k = wr ? K_ERR : K_STATUS;
    end else if ((addr >= MEM_BASE) && (addr <= MEM_LAST)) begin
      k = K_MEM;
    end else begin
      k = K_ERR;
    end
    return k;
  endfunction

  state_e         state_q, state_d;
  kind_e          kind_q, kind_d;
  logic           write_q, write_d;
  logic           req_ready_q, req_ready_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [31:0]    rsp_rdata_q, rsp_rdata_d;
  logic           rsp_err_q, rsp_err_d;
  logic           count_we_q, count_we_d;
  logic [31:0]    count_in_q, count_in_d;
  logic           config_we_q, config_we_d;
  logic [2:0]     cfg_q, cfg_d;
  logic           mem_write_en_q, mem_write_en_d;
  logic [AW-1:0]  mem_address_q, mem_address_d;
  logic [31:0]    mem_data_in_q, mem_data_in_d;
  kind_e          req_kind_s;
  logic [11:0]    mem_off_s;

  // Next-state and next-output logic; strobes are one-cycle pulses launched at accept.
  always_comb begin
    state_d        = state_q;
    kind_d         = kind_q;
    write_d        = write_q;
    rsp_rdata_d    = rsp_rdata_q;
    rsp_err_d      = rsp_err_q;
    count_we_d     = 1'b0;
    count_in_d     = count_in_q;
    config_we_d    = 1'b0;
    cfg_d          = cfg_q;
    mem_write_en_d = 1'b0;
    mem_address_d  = mem_address_q;
    mem_data_in_d  = mem_data_in_q;
    req_kind_s     = decode(bus.bus_req_addr, bus.bus_req_write);
    mem_off_s      = bus.bus_req_addr - MEM_BASE;

    case (state_q)
      S_IDLE: begin
        if (bus.bus_req_valid && req_ready_q) begin
          write_d     = bus.bus_req_write;
          kind_d      = req_kind_s;
          rsp_rdata_d = 32'h0000_0000;
          rsp_err_d   = (req_kind_s == K_ERR);
          state_d     = S_EXEC;
          if (bus.bus_req_write) begin
            case (req_kind_s)
              K_COUNT: begin
                count_we_d = 1'b1;
                count_in_d = bus.bus_req_wdata;
              end
              K_CONFIG: begin
                config_we_d = 1'b1;
                cfg_d       = bus.bus_req_wdata[2:0];
              end
              K_MEM: begin
                mem_write_en_d = 1'b1;
                mem_address_d  = mem_off_s[AW+1:2];
                mem_data_in_d  = bus.bus_req_wdata;
              end
              default: begin
                count_we_d = 1'b0;
              end
            endcase
          end else begin
            if (req_kind_s == K_MEM) begin
              mem_address_d = mem_off_s[AW+1:2];
            end else begin
              mem_address_d = mem_address_q;
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_EXEC: begin
        if (!write_q) begin
          case (kind_q)
            K_COUNT:  rsp_rdata_d = count_out;
            K_CONFIG: rsp_rdata_d = {29'h0, count_ire_out, count_dir_out, count_en_out};
            K_STATUS: rsp_rdata_d = {31'h0, count_lt_1k_out};
            default:  rsp_rdata_d = rsp_rdata_q;
          endcase
        end else begin
          rsp_rdata_d = rsp_rdata_q;
        end
        if (!write_q && (kind_q == K_MEM)) begin
          state_d = S_MEM_WAIT;
        end else begin
          state_d = S_RESP;
        end
      end

      S_MEM_WAIT: begin
        rsp_rdata_d = mem_data_out;
        state_d     = S_RESP;
      end

      S_RESP: begin
        if (bus.bus_rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
  end

  // State and output registers with synchronous reset dropping any pending transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      kind_q         <= K_COUNT;
      write_q        <= 1'b0;
      req_ready_q    <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= 32'h0000_0000;
      rsp_err_q      <= 1'b0;
      count_we_q     <= 1'b0;
      count_in_q     <= 32'h0000_0000;
      config_we_q    <= 1'b0;
      cfg_q          <= 3'b000;
      mem_write_en_q <= 1'b0;
      mem_address_q  <= '0;
      mem_data_in_q  <= 32'h0000_0000;
    end else begin
      state_q        <= state_d;
      kind_q         <= kind_d;
      write_q        <= write_d;
      req_ready_q    <= req_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rsp_err_q      <= rsp_err_d;
      count_we_q     <= count_we_d;
      count_in_q     <= count_in_d;
      config_we_q    <= config_we_d;
      cfg_q          <= cfg_d;
      mem_write_en_q <= mem_write_en_d;
      mem_address_q  <= mem_address_d;
      mem_data_in_q  <= mem_data_in_d;
    end
  end

  assign bus.bus_req_ready = req_ready_q;
  assign bus.bus_rsp_valid = rsp_valid_q;
  assign bus.bus_rsp_rdata = rsp_rdata_q;
  assign bus.bus_rsp_err   = rsp_err_q;
  assign count_we          = count_we_q;
  assign count_in          = count_in_q;
  assign count_config_we   = config_we_q;
  assign count_en_in       = cfg_q[0];
  assign count_dir_in      = cfg_q[1];
  assign count_ire_in      = cfg_q[2];
  assign mem_write_en      = mem_write_en_q;
  assign mem_address       = mem_address_q;
  assign mem_data_in       = mem_data_in_q;

endmodule

// File: tb/tb_peripheral_bus_bridge.sv
// Randomized self-checking bench for peripheral_bus_bridge with a counter-core
// stub, a memory stub and an address-map reference model.
module tb_peripheral_bus_bridge;

  logic        clk;
  logic        reset;
  logic        count_we, count_config_we;
  logic [31:0] count_in;
  logic        count_en_in, count_dir_in, count_ire_in;
  logic [31:0] core_count;
  logic        core_en, core_dir, core_ire;
  logic        mem_write_en;
  logic [7:0]  mem_address;
  logic [31:0] mem_data_in, mem_data_out;
  logic [31:0] stub_mem [256];

  int          err_cnt = 0;
  int          chk_cnt = 0;
  int          n_cwe = 0, n_fwe = 0, n_mwe = 0;

  logic [31:0] model_count;
  logic [2:0]  model_cfg;
  logic [31:0] model_mem [256];
  logic [11:0] edge_addrs [4] = '{12'h3FC, 12'h400, 12'h7FC, 12'h800};

  peripheral_bus_bridge_if bus ();

  peripheral_bus_bridge dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus),
    .count_we        (count_we),
    .count_in        (count_in),
    .count_config_we (count_config_we),
    .count_en_in     (count_en_in),
    .count_dir_in    (count_dir_in),
    .count_ire_in    (count_ire_in),
    .count_out       (core_count),
    .count_en_out    (core_en),
    .count_dir_out   (core_dir),
    .count_ire_out   (core_ire),
    .count_lt_1k_out (core_count < 32'd1000),
    .mem_write_en    (mem_write_en),
    .mem_address     (mem_address),
    .mem_data_in     (mem_data_in),
    .mem_data_out    (mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter core stub: load strobe wins over counting.
  always @(posedge clk) begin
    if (reset) begin
      core_count <= 32'h0;
      {core_ire, core_dir, core_en} <= 3'b000;
    end else begin
      if (count_we) core_count <= count_in;
      else if (core_en) core_count <= core_dir ? core_count + 32'd1 : core_count - 32'd1;
      if (count_config_we) {core_ire, core_dir, core_en} <= {count_ire_in, count_dir_in, count_en_in};
    end
  end

  // Single-port memory stub with one-cycle read latency.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) stub_mem[i] <= 32'h0;
    end else if (mem_write_en) begin
      stub_mem[mem_address] <= mem_data_in;
    end
    mem_data_out <= stub_mem[mem_address];
  end

  // Strobe pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (count_we) n_cwe++;
    if (count_config_we) n_fwe++;
    if (mem_write_en) n_mwe++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit in_mem(input logic [11:0] a);
    return (a >= 12'h400) && (a <= 12'h7FC);
  endfunction

  function automatic bit addr_err(input logic [11:0] a, input logic w);
    if (a[1:0] != 2'b00) return 1'b1;
    if (a == 12'h000 || a == 12'h004 || in_mem(a)) return 1'b0;
    if (a == 12'h008) return w;
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_read(input logic [11:0] a);
    if (a == 12'h000) return model_count;
    if (a == 12'h004) return {29'h0, model_cfg};
    if (a == 12'h008) return (model_count < 32'd1000) ? 32'd1 : 32'd0;
    return model_mem[(int'(a) - 1024) / 4];
  endfunction

  task automatic model_reset();
    model_count = 32'h0;
    model_cfg   = 3'b000;
    for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
  endtask

  // One full transaction, checked against the model; hold = cycles rsp_ready is withheld.
  task automatic run_txn(input logic wr, input logic [11:0] a, input logic [31:0] wd,
                         input int hold, input bit cmp_data, output logic [31:0] rd);
    bit e, cwe, fwe, mwe, mrd;
    int idx, lat, t, rem, b0, b1, b2;
    logic [31:0] exp_rd, r0;
    logic e0;
    e   = addr_err(a, wr);
    cwe = wr && !e && (a == 12'h000);
    fwe = wr && !e && (a == 12'h004);
    mwe = wr && !e && in_mem(a);
    mrd = !wr && !e && in_mem(a);
    idx = (int'(a) - 1024) / 4;
    exp_rd = (wr || e) ? 32'h0 : exp_read(a);
    rd = 32'h0;
    b0 = n_cwe; b1 = n_fwe; b2 = n_mwe;
    @(negedge clk);
    bus.bus_req_valid = 1'b1;
    bus.bus_req_write = wr;
    bus.bus_req_addr  = a;
    bus.bus_req_wdata = wd;
    bus.bus_rsp_ready = (hold == 0);
    t = 0;
    while (!bus.bus_req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!bus.bus_req_ready) begin
      check_eq("accept_timeout", 32'd0, 32'd1);
      bus.bus_req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.bus_req_valid = 1'b0;
    check_eq("count_we", 32'(count_we), 32'(cwe));
    check_eq("config_we", 32'(count_config_we), 32'(fwe));
    check_eq("mem_we", 32'(mem_write_en), 32'(mwe));
    check_eq("req_ready_busy", 32'(bus.bus_req_ready), 32'd0);
    if (cwe) check_eq("count_in", count_in, wd);
    if (fwe) check_eq("config_bits", 32'({count_ire_in, count_dir_in, count_en_in}), 32'(wd[2:0]));
    if (mwe || mrd) check_eq("mem_addr", 32'(mem_address), 32'(idx));
    if (mwe) check_eq("mem_wdata", mem_data_in, wd);
    lat = 1;
    while (!bus.bus_rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.bus_rsp_valid) begin
      check_eq("rsp_timeout", 32'd0, 32'd1);
      return;
    end
    check_eq("latency", 32'(lat), mrd ? 32'd3 : 32'd2);
    check_eq("rsp_err", 32'(bus.bus_rsp_err), 32'(e));
    if (cmp_data) check_eq("rsp_rdata", bus.bus_rsp_rdata, exp_rd);
    if (cwe) check_eq("count_loaded", core_count, wd);
    r0 = bus.bus_rsp_rdata;
    e0 = bus.bus_rsp_err;
    rd = r0;
    rem = hold;
    while (rem > 0) begin
      bus.bus_req_valid = 1'b1;
      bus.bus_req_write = 1'b1;
      bus.bus_req_addr  = 12'h000;
      bus.bus_req_wdata = 32'hBAD0_0000;
      @(negedge clk);
      rem--;
      check_eq("hold_valid", 32'(bus.bus_rsp_valid), 32'd1);
      check_eq("hold_rdata", bus.bus_rsp_rdata, r0);
      check_eq("hold_err", 32'(bus.bus_rsp_err), 32'(e0));
      check_eq("hold_req_ready", 32'(bus.bus_req_ready), 32'd0);
      if (rem == 0) begin
        bus.bus_rsp_ready = 1'b1;
        bus.bus_req_valid = 1'b0;
      end
    end
    @(posedge clk);
    check_eq("n_count_we", 32'(n_cwe - b0), 32'(cwe));
    check_eq("n_config_we", 32'(n_fwe - b1), 32'(fwe));
    check_eq("n_mem_we", 32'(n_mwe - b2), 32'(mwe));
    if (cwe) model_count = wd;
    if (fwe) model_cfg = wd[2:0];
    if (mwe) model_mem[idx] = wd;
  endtask

  initial begin
    logic [31:0] rd, r1, r2, wd;
    logic [11:0] a;
    logic        wr;
    int          sel, t;

    bus.bus_req_valid = 1'b0;
    bus.bus_req_write = 1'b0;
    bus.bus_req_addr  = 12'h000;
    bus.bus_req_wdata = 32'h0;
    bus.bus_rsp_ready = 1'b0;
    model_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_ready", 32'(bus.bus_req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(bus.bus_rsp_valid), 32'd0);
    check_eq("rst_rsp_rdata", bus.bus_rsp_rdata, 32'd0);
    check_eq("rst_rsp_err", 32'(bus.bus_rsp_err), 32'd0);
    check_eq("rst_strobes", 32'({count_we, count_config_we, mem_write_en}), 32'd0);
    check_eq("rst_count_in", count_in, 32'd0);
    check_eq("rst_mem_addr", 32'(mem_address), 32'd0);
    check_eq("rst_mem_wdata", mem_data_in, 32'd0);
    check_eq("rst_cfg", 32'({count_ire_in, count_dir_in, count_en_in}), 32'd0);
    reset = 1'b0;

    run_txn(1'b1, 12'h000, 32'h0000_1234, 0, 1'b1, rd);
    run_txn(1'b0, 12'h000, 32'h0, 0, 1'b1, rd);

    run_txn(1'b1, 12'h000, 32'd5, 0, 1'b1, rd);
    run_txn(1'b1, 12'h004, 32'h7, 0, 1'b1, rd);
    run_txn(1'b0, 12'h004, 32'h0, 0, 1'b1, rd);
    run_txn(1'b0, 12'h000, 32'h0, 0, 1'b0, r1);
    run_txn(1'b0, 12'h000, 32'h0, 0, 1'b0, r2);
    check_eq("count_delta", r2 - r1, 32'd3);
    check_eq("count_moved", 32'(r1 > 32'd5), 32'd1);
    run_txn(1'b1, 12'h004, 32'h0, 0, 1'b1, rd);
    run_txn(1'b1, 12'h000, 32'd10, 0, 1'b1, rd);
    run_txn(1'b0, 12'h008, 32'h0, 0, 1'b1, rd);
    check_eq("status_lt1k", rd, 32'h1);

    run_txn(1'b1, 12'h404, 32'hDEAD_BEEF, 0, 1'b1, rd);
    run_txn(1'b0, 12'h404, 32'h0, 0, 1'b1, rd);

    run_txn(1'b1, 12'h008, 32'hFFFF_FFFF, 0, 1'b1, rd);
    run_txn(1'b0, 12'h00C, 32'h0, 0, 1'b1, rd);
    run_txn(1'b0, 12'h002, 32'h0, 0, 1'b1, rd);

    run_txn(1'b0, 12'h404, 32'h0, 5, 1'b1, rd);

    // Reset while the memory read is waiting on data.
    @(negedge clk);
    bus.bus_req_valid = 1'b1;
    bus.bus_req_write = 1'b0;
    bus.bus_req_addr  = 12'h404;
    bus.bus_rsp_ready = 1'b1;
    t = 0;
    while (!bus.bus_req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_eq("rst_txn_accept", 32'(bus.bus_req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.bus_req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("midrst_rsp_valid", 32'(bus.bus_rsp_valid), 32'd0);
    check_eq("midrst_req_ready", 32'(bus.bus_req_ready), 32'd0);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check_eq("midrst_idle", 32'(bus.bus_req_ready), 32'd1);
    repeat (3) begin
      @(negedge clk);
      check_eq("midrst_no_rsp", 32'(bus.bus_rsp_valid), 32'd0);
    end
    run_txn(1'b0, 12'h404, 32'h0, 0, 1'b1, rd);

    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 9));
      wr  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      case (sel)
        0: a = 12'h000;
        1: a = 12'h004;
        2: a = 12'h008;
        3, 4, 5: a = 12'h400 + 12'(4 * $urandom_range(0, 15));
        6: a = edge_addrs[$urandom_range(0, 3)];
        7: begin
          a = 12'($urandom);
          if (a[1:0] == 2'b00) a[0] = 1'b1;
        end
        8: a = 12'h00C + 12'(4 * $urandom_range(0, 252));
        default: a = 12'h800 + 12'(4 * $urandom_range(0, 511));
      endcase
      if (a == 12'h004) wd[0] = 1'b0;
      if (a == 12'h000 && $urandom_range(0, 1) == 1) wd = 32'($urandom_range(0, 2000));
      run_txn(wr, a, wd, int'($urandom_range(0, 2)), 1'b1, rd);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/peripheral_bus_bridge.md
Name: peripheral_bus_bridge

Overview:
Bus-side initiator for the counter peripheral: accepts word transactions on a valid/ready request/response bus and drives the peripheral's native register strobes and its single-port memory. Decodes a 12-bit byte address into COUNT, CONFIG, STATUS and a 256-word memory window. Returns read data or an error per transaction. Sits between the system bus fabric and the counter core; one transaction is outstanding at a time.

Parameters:
MEM_BASE, 12'h400, byte base of 256x32 memory window (window = MEM_BASE..MEM_BASE+12'h3FC)
MEM_DEPTH, 256, memory words; mem_address width = $clog2(MEM_DEPTH)

Ports:
clk  in  1  single clock, all logic rising-edge
reset  in  1  synchronous, active-high
bus_req_valid  in  1  request valid
bus_req_ready  out  1  request accept
bus_req_write  in  1  1=write, 0=read
bus_req_addr  in  12  byte address
bus_req_wdata  in  32  write data
bus_rsp_valid  out  1  response valid
bus_rsp_ready  in  1  response accept
bus_rsp_rdata  out  32  read data (0 for writes/errors)
bus_rsp_err  out  1  decode/access error
count_we  out  1  one-cycle COUNT load strobe
count_in  out  32  COUNT load value
count_config_we  out  1  one-cycle CONFIG load strobe
count_en_in, count_dir_in, count_ire_in  out  1 each  CONFIG load values
count_out  in  32  current count
count_en_out, count_dir_out, count_ire_out, count_lt_1k_out  in  1 each  current config/status
mem_write_en  out  1  memory write strobe
mem_address  out  8  memory word address
mem_data_in  out  32  memory write data
mem_data_out  in  32  memory read data, valid one cycle after address presented

Behaviour:
- Clock clk, reset synchronous active-high. During/after reset: bus_req_ready=0 while reset high, bus_rsp_valid=0, bus_rsp_rdata=0, bus_rsp_err=0, all strobes 0, count_in/mem_data_in/mem_address/config values 0, state IDLE.
- Address map (word aligned): 12'h000 COUNT RW; 12'h004 CONFIG RW, bits [0]=en,[1]=dir,[2]=ire, others read 0/ignored; 12'h008 STATUS RO, bit[0]=lt_1k; MEM window RW, mem_address = addr[9:2].
- Error: addr[1:0]!=0, unmapped address, or write to STATUS -> no strobe, no memory access, response err=1, rdata=0.
- FSM states: IDLE, EXEC, MEM_WAIT, RESP.
- IDLE: bus_req_ready=1. On valid&ready (cycle N) register write, addr, wdata; go EXEC.
- EXEC (N+1): register write -> assert count_we or count_config_we for exactly this cycle with registered data; count_in=wdata; config bits=wdata[2:0]. Register read -> sample count_out / {29'b0,ire,dir,en} / {31'b0,lt_1k} into rdata. Memory write -> mem_write_en=1 this cycle. Memory read -> drive mem_address, go MEM_WAIT. Otherwise go RESP.
- MEM_WAIT (N+2): capture mem_data_out into rdata; go RESP.
- RESP: bus_rsp_valid=1, rdata/err stable until bus_rsp_ready; on valid&ready return IDLE. rsp_valid first asserted N+2 (registers, mem write, errors) or N+3 (mem read).
- bus_req_ready=0 in all states except IDLE; back-to-back minimum spacing 3 cycles (register) / 4 cycles (memory read) with rsp_ready tied high.
- COUNT read returns count_out value present during EXEC; counter motion afterwards is not reflected.
- COUNT write: count_out equals wdata at N+2 (core loads at N+1 edge); core's own count/enable logic yields to count_we that cycle.
- mem_address, mem_data_in hold last driven value outside strobe cycles; mem_write_en never asserted except EXEC of a valid memory write.
- Reset mid-transaction: any state -> IDLE next cycle; pending transaction dropped, no response, no further strobes.
- bus_rsp_ready high outside RESP has no effect; bus_req_valid outside IDLE is ignored (not accepted).

Test Plan:
- Reset, write 32'h0000_1234 to 12'h000, read 12'h000 with CONFIG en=0 -> count_we one cycle at N+1, rsp err=0; read returns 32'h0000_1234.
- Write 32'h7 to 12'h004, then read 12'h000 twice spaced 3 cycles after COUNT=5 -> CONFIG read 32'h7; counter counting up: second COUNT read exceeds first by 3.
- Write 32'hDEAD_BEEF to 12'h404, read 12'h404 -> mem_write_en at address 1; read response at N+3 with 32'hDEAD_BEEF.
- Write to 12'h008, read 12'h00C, read 12'h002 -> all err=1, rdata 0, no strobes; STATUS read with COUNT=10 returns 32'h1.
- Hold bus_rsp_ready=0 for 5 cycles on a read -> rsp_valid/rdata stable, bus_req_ready=0 throughout; no second accept.
- Assert reset in MEM_WAIT -> no response, IDLE next cycle, next read completes normally.
